hdc_mem_fetch_ctrl: RTL
=======================

Name: hdc_mem_fetch_ctrl

Overview:
- Parametrised sequencer for the item/projection memory fetches that feed the spatial encoder.
- Replaces the fixed nine-bank ready/valid wiring and single shared address with an N-bank controller.
- Two fetch modes: broadcast (all banks per address) and round-robin (one bank per word).
- Adds per-word delivery handshake, last-word marking and a sticky timeout error; sits between the sample-valid input and the spatial encoder's memory interface.

Parameters:
- NUM_BANKS, 9, number of memory banks handled (>=1).
- ADDR_WIDTH, 8, width of SramAddr_DO.
- DEPTH, 256, words fetched per sample (1..2^ADDR_WIDTH).
- TIMEOUT_CYCLES, 64, max cycles per address step in ISSUE+WAIT before abort (>=2).
- BIDX_W, max(1,$clog2(NUM_BANKS)), derived width of the bank index.

Ports:
- Clk_CI  in  1  clock, rising edge.
- Reset_RI  in  1  reset, asynchronous, active-low.
- ValidIn_SI  in  1  new sample available.
- ReadyOut_SO  out  1  controller idle, accepts a sample.
- Mode_SI  in  1  0=broadcast, 1=round-robin; sampled at sample accept.
- BankReady_SI  in  NUM_BANKS  bank i can accept a request.
- BankReq_SO  out  NUM_BANKS  read request to bank i.
- BankValid_SI  in  NUM_BANKS  bank i read data valid (1-cycle pulse).
- SramAddr_DO  out  ADDR_WIDTH  address shared by all banks.
- WordValid_SO  out  1  fetched word(s) available to encoder.
- WordReady_SI  in  1  encoder consumes word.
- WordBank_DO  out  BIDX_W  bank index of word (round-robin); 0 in broadcast.
- WordLast_SO  out  1  final word of the sample.
- Busy_SO  out  1  not IDLE.
- ErrTimeout_SO  out  1  sticky timeout flag.
- ErrClear_SI  in  1  clears ErrTimeout_SO.

Behaviour:
- Reset (async, Reset_RI=0): state IDLE; addr, bank index, masks, timeout counter = 0; BankReq_SO=0, WordValid_SO=0, WordLast_SO=0, WordBank_DO=0, SramAddr_DO=0, Busy_SO=0, ErrTimeout_SO=0.
- ReadyOut_SO = (state==IDLE). It is 1 during and directly after reset.
- Reset mid-operation aborts immediately; no further requests or words are issued.

State machine:
- IDLE: on ValidIn_SI & ReadyOut_SO, latch Mode_SI, addr=0, bidx=0, go to ISSUE.
- ISSUE: target mask T = all ones (broadcast) or one-hot(bidx) (round-robin). BankReq_SO[i] = T[i] & ~accepted[i]. Request i is accepted in a cycle with BankReq_SO[i] & BankReady_SI[i]. When all of T is accepted (that cycle inclusive), go to WAIT.
- WAIT: done[i] is set on BankValid_SI[i] only if accepted[i] was set in an earlier cycle. Valids on other banks, or in the acceptance cycle, are ignored. When done==T, go to DELIVER.
- DELIVER: WordValid_SO=1, WordBank_DO=bidx (or 0 in broadcast), SramAddr_DO stable. WordLast_SO=1 when addr==DEPTH-1 and (broadcast, or bidx==NUM_BANKS-1). Outputs are held until WordReady_SI.
- On the DELIVER handshake:
  - Broadcast: addr+1.
  - Round-robin: bidx+1; when bidx wraps from NUM_BANKS-1 to 0, addr+1.
  - If WordLast_SO: go to IDLE, counters reset to 0.
  - Else: clear accepted/done masks, go to ISSUE in the next cycle.

Address and timeout rules:
- SramAddr_DO is valid and stable from ISSUE entry through DELIVER handshake for each step.
- Timeout counter: cleared on ISSUE entry, increments each ISSUE/WAIT cycle.
- On reaching TIMEOUT_CYCLES: ErrTimeout_SO=1, BankReq_SO=0, go to IDLE. No WordValid_SO is issued for that step.
- ErrClear_SI clears the flag in any state. Set wins over clear in the same cycle.
- Mode_SI changes outside the accept cycle have no effect.
- DEPTH=1, NUM_BANKS=1: a single word with WordLast_SO=1.

Test Plan:
- Broadcast, NUM_BANKS=9, DEPTH=4: all banks ready, valid 2 cycles after accept -> 4 words at addr 0..3, WordLast_SO only on addr 3, ReadyOut_SO back to 1 next cycle.
- Round-robin, NUM_BANKS=3, DEPTH=2: -> 6 words, WordBank_DO sequence 0,1,2,0,1,2, SramAddr_DO 0,0,0,1,1,1, WordLast_SO on 6th.
- Bank 4 BankReady_SI held low 5 cycles, broadcast: -> BankReq_SO[4] stays high 6 cycles, others drop after acceptance, word delivered only after bank 4 valid.
- Bank 2 never returns valid, TIMEOUT_CYCLES=8: -> ErrTimeout_SO=1 after 8 cycles in ISSUE/WAIT, IDLE, no WordValid_SO. ErrClear_SI pulse -> flag 0. Next sample runs normally.
- WordReady_SI low 3 cycles in DELIVER: -> WordValid_SO, SramAddr_DO, WordBank_DO stable. Stray BankValid_SI before acceptance is ignored.
- Reset_RI pulsed low mid-WAIT at addr 2: -> BankReq_SO=0 and Busy_SO=0 immediately (asynchronous), ReadyOut_SO=1, next sample restarts at addr 0.

Source files
------------

// File: rtl/hdc_mem_fetch_ctrl.sv
// hdc_mem_fetch_ctrl: N-bank item/projection memory fetch sequencer.
// For every sample it walks DEPTH addresses, issues read requests to the
// banks (all banks per address in broadcast, one bank per word in
// round-robin), waits for their read-valid pulses and then hands one word
// per step to the spatial encoder with a ready/valid handshake.
module hdc_mem_fetch_ctrl #(
  parameter int NUM_BANKS      = 9,
  parameter int ADDR_WIDTH     = 8,
  parameter int DEPTH          = 256,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int BIDX_W         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                  Clk_CI,
  input  logic                  Reset_RI,
  input  logic                  ValidIn_SI,
  output logic                  ReadyOut_SO,
  input  logic                  Mode_SI,
  input  logic [NUM_BANKS-1:0]  BankReady_SI,
  output logic [NUM_BANKS-1:0]  BankReq_SO,
  input  logic [NUM_BANKS-1:0]  BankValid_SI,
  output logic [ADDR_WIDTH-1:0] SramAddr_DO,
  output logic                  WordValid_SO,
  input  logic                  WordReady_SI,
  output logic [BIDX_W-1:0]     WordBank_DO,
  output logic                  WordLast_SO,
  output logic                  Busy_SO,
  output logic                  ErrTimeout_SO,
  input  logic                  ErrClear_SI
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [BIDX_W-1:0]     LAST_BANK = BIDX_W'(NUM_BANKS - 1);
  localparam logic [TCNT_W-1:0]     TO_LIMIT  = TCNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

  state_t                state;
  logic                  mode;       // 0 broadcast, 1 round-robin
  logic [ADDR_WIDTH-1:0] addr;
  logic [BIDX_W-1:0]     bidx;
  logic [NUM_BANKS-1:0]  accepted;   // requests taken by the bank this step
  logic [NUM_BANKS-1:0]  done;       // read data returned this step
  logic [TCNT_W-1:0]     tcnt;
  logic                  err;

  logic [NUM_BANKS-1:0]  target;
  logic [NUM_BANKS-1:0]  req;
  logic [NUM_BANKS-1:0]  acc_all;
  logic [NUM_BANKS-1:0]  done_nxt;
  logic                  issue_done;
  logic                  wait_done;
  logic                  tcnt_hit;
  logic                  abort;
  logic                  last_word;

  // Step bookkeeping: which banks this step needs, what is still pending,
  // and whether the step finished or ran out of time this cycle.
  always_comb begin
    target = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      target[i] = ~mode | (bidx == BIDX_W'(i));
    req        = (state == S_ISSUE) ? (target & ~accepted) : '0;
    acc_all    = accepted | (req & BankReady_SI);
    // Only banks accepted in an earlier cycle may complete; this drops
    // stray valids and valids coinciding with the acceptance cycle.
    done_nxt   = done | (BankValid_SI & accepted & target);
    issue_done = ((acc_all & target) == target);
    wait_done  = ((done_nxt & target) == target);
    tcnt_hit   = ((tcnt + TCNT_W'(1)) == TO_LIMIT);
    abort      = ((state == S_ISSUE) && !issue_done && tcnt_hit) ||
                 ((state == S_WAIT)  && !wait_done  && tcnt_hit);
    last_word  = (addr == LAST_ADDR) && (!mode || (bidx == LAST_BANK));
  end

  // Fetch sequencer plus sticky timeout flag (a timeout beats a clear).
  always_ff @(posedge Clk_CI or negedge Reset_RI) begin
    if (!Reset_RI) begin
      state    <= S_IDLE;
      mode     <= 1'b0;
      addr     <= '0;
      bidx     <= '0;
      accepted <= '0;
      done     <= '0;
      tcnt     <= '0;
      err      <= 1'b0;
    end else begin
      if (abort)            err <= 1'b1;
      else if (ErrClear_SI) err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (ValidIn_SI) begin
            mode     <= Mode_SI;
            addr     <= '0;
            bidx     <= '0;
            accepted <= '0;
            done     <= '0;
            tcnt     <= '0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (state == S_ISSUE) accepted <= acc_all;
          done <= done_nxt;
          tcnt <= tcnt + TCNT_W'(1);
          if (state == S_ISSUE && issue_done)     state <= S_WAIT;
          else if (state == S_WAIT && wait_done)  state <= S_DELIVER;
          else if (abort) begin
            state    <= S_IDLE;
            addr     <= '0;
            bidx     <= '0;
            accepted <= '0;
            done     <= '0;
            tcnt     <= '0;
          end
        end
        S_DELIVER: begin
          if (WordReady_SI) begin
            accepted <= '0;
            done     <= '0;
            tcnt     <= '0;
            if (last_word) begin
              state <= S_IDLE;
              addr  <= '0;
              bidx  <= '0;
            end else begin
              state <= S_ISSUE;
              if (!mode) begin
                addr <= addr + ADDR_WIDTH'(1);
              end else if (bidx == LAST_BANK) begin
                bidx <= '0;
                addr <= addr + ADDR_WIDTH'(1);
              end else begin
                bidx <= bidx + BIDX_W'(1);
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state only, so reset clears them
  // immediately and nothing depends combinationally on the inputs.
  assign BankReq_SO    = req;
  assign SramAddr_DO   = addr;
  assign WordValid_SO  = (state == S_DELIVER);
  assign WordBank_DO   = bidx;
  assign WordLast_SO   = (state == S_DELIVER) && last_word;
  assign Busy_SO       = (state != S_IDLE);
  assign ReadyOut_SO   = (state == S_IDLE);
  assign ErrTimeout_SO = err;

endmodule
